// File: rtl/victim_select_ctrl_pkg.sv
// Shared types and sizing constants for the victim-selection replacement controller.
package victim_select_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam int LINES  = 32;
  localparam int SCAN_W = 8;
  localparam int IDX_W  = $clog2(LINES);
  localparam int NGRP   = LINES / SCAN_W;

endpackage

// File: rtl/victim_select_ctrl_group_pick.sv
// Folds one group of SCAN_W lines into the running best victim candidate.
// Invalid lines dominate (first one found sticks); among valid lines a strictly
// greater age is needed to displace the incumbent, so ties keep the lowest index.
module victim_group_pick
  import victim_select_ctrl_pkg::*;
#(
  parameter int K      = 3,
  parameter int SCAN_W = 8
) (
  input  logic [SCAN_W*K-1:0] ages,
  input  logic [SCAN_W-1:0]   valids,
  input  logic [IDX_W-1:0]    base,
  input  logic [IDX_W-1:0]    best_idx_in,
  input  logic [K-1:0]        best_age_in,
  input  logic                best_inv_in,
  output logic [IDX_W-1:0]    best_idx_out,
  output logic [K-1:0]        best_age_out,
  output logic                best_inv_out
);

  // Walk the group in ascending index order, updating the candidate line by line.
  always_comb begin
    best_idx_out = best_idx_in;
    best_age_out = best_age_in;
    best_inv_out = best_inv_in;
    for (int i = 0; i < SCAN_W; i++) begin
      if (!best_inv_out) begin
        if (!valids[i]) begin
          best_inv_out = 1'b1;
          best_idx_out = base + IDX_W'(i);
          best_age_out = '0;
        end else if (ages[i*K +: K] > best_age_out) begin
          best_idx_out = base + IDX_W'(i);
          best_age_out = ages[i*K +: K];
        end
      end
    end
  end

endmodule

// File: rtl/victim_select_ctrl.sv
// Replacement controller: snapshots ages/valid bits on a miss, scans them in
// groups to choose a victim, runs the refill handshake, then issues the
// one-cycle install strobe to the age block.
module victim_select_ctrl
  import victim_select_ctrl_pkg::*;
#(
  parameter int K      = 3,
  parameter int LINES  = 32,
  parameter int SCAN_W = 8,
  parameter int AW     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_req,
  input  logic [AW-1:0]      miss_addr,
  input  logic [LINES-1:0]   valid_vec,
  input  logic [LINES*K-1:0] age_1D,
  output logic               mem_req,
  output logic [AW-1:0]      mem_addr,
  input  logic               mem_ack,
  input  logic               fill_done,
  output logic               we,
  output logic [IDX_W-1:0]   write_addr,
  output logic [IDX_W-1:0]   victim_idx,
  output logic               busy,
  output logic               done
);

  localparam int NUM_GRP = LINES / SCAN_W;
  localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  state_t             state;
  logic [GRP_W-1:0]   grp;
  logic [LINES*K-1:0] age_snap;
  logic [LINES-1:0]   valid_snap;
  logic [AW-1:0]      addr_snap;
  logic [IDX_W-1:0]   best_idx;
  logic [K-1:0]       best_age;
  logic               best_inv;

  logic [SCAN_W*K-1:0] grp_ages;
  logic [SCAN_W-1:0]   grp_valid;
  logic [IDX_W-1:0]    grp_base;
  logic [IDX_W-1:0]    pick_idx;
  logic [K-1:0]        pick_age;
  logic                pick_inv;

  assign mem_addr = addr_snap;

  // Select the snapshot slice for the group currently being scanned.
  always_comb begin
    grp_ages  = age_snap[int'(grp)*SCAN_W*K +: SCAN_W*K];
    grp_valid = valid_snap[int'(grp)*SCAN_W +: SCAN_W];
    grp_base  = IDX_W'(int'(grp) * SCAN_W);
  end

  victim_group_pick #(
    .K      (K),
    .SCAN_W (SCAN_W)
  ) u_pick (
    .ages         (grp_ages),
    .valids       (grp_valid),
    .base         (grp_base),
    .best_idx_in  (best_idx),
    .best_age_in  (best_age),
    .best_inv_in  (best_inv),
    .best_idx_out (pick_idx),
    .best_age_out (pick_age),
    .best_inv_out (pick_inv)
  );

  // Controller FSM; every handshake output is a flop set on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grp        <= '0;
      age_snap   <= '0;
      valid_snap <= '0;
      addr_snap  <= '0;
      best_idx   <= '0;
      best_age   <= '0;
      best_inv   <= 1'b0;
      victim_idx <= '0;
      write_addr <= '0;
      mem_req    <= 1'b0;
      we         <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            age_snap   <= age_1D;
            valid_snap <= valid_vec;
            addr_snap  <= miss_addr;
            grp        <= '0;
            best_idx   <= '0;
            best_age   <= '0;
            best_inv   <= 1'b0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          best_idx <= pick_idx;
          best_age <= pick_age;
          best_inv <= pick_inv;
          if (grp == GRP_W'(NUM_GRP - 1)) begin
            grp        <= '0;
            victim_idx <= pick_idx;
            mem_req    <= 1'b1;
            state      <= REQ;
          end else begin
            grp <= grp + GRP_W'(1);
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (fill_done) begin
            we         <= 1'b1;
            done       <= 1'b1;
            write_addr <= victim_idx;
            state      <= WRITE;
          end
        end
        WRITE: begin
          we    <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          we      <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
